ahb_bridge_arbiter: RTL and testbench

Two-requester arbiter and transfer sequencer in front of the AHB slave port of `Bridge_Top`. Each requester posts single read/write commands over a valid/ready handshake. The block grants one requester at a time with round-robin priority, then sequences one AHB-Lite NONSEQ single transfer (address phase, then data phase). It returns read data and error status to the granted requester, and flags stalled transfers with a watchdog.

---
 rtl/ahb_bridge_arbiter_if.sv | 25 ++
 rtl/ahb_bridge_arbiter.sv | 73 +++++++
 tb/tb_ahb_bridge_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bridge_arbiter_if.sv
// ahb_bridge_arbiter_if: requester handshakes plus the AHB-Lite signals toward the bridge
interface ahb_bridge_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic req0_valid, req1_valid, req0_ready, req1_ready, req0_write, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr, Haddr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, rsp_rdata, Hwdata, Hrdata;
  logic rsp0_valid, rsp1_valid, rsp_err;
  logic Hwrite, Hreadyin, Hreadyout;
  logic [1:0] Htrans, Hresp;
  logic busy, gnt_id, timeout_flag;
  modport master (
    input req0_valid, req1_valid, req0_write, req1_write, req0_addr, req1_addr,
    input req0_wdata, req1_wdata, Hreadyout, Hresp, Hrdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    output Haddr, Hwrite, Htrans, Hwdata, Hreadyin, busy, gnt_id, timeout_flag
  );
  modport slave (
    output req0_valid, req1_valid, req0_write, req1_write, req0_addr, req1_addr,
    output req0_wdata, req1_wdata, Hreadyout, Hresp, Hrdata,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    input Haddr, Hwrite, Htrans, Hwdata, Hreadyin, busy, gnt_id, timeout_flag
  );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: round-robin two-requester arbiter sequencing single AHB-Lite NONSEQ transfers
module ahb_bridge_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input logic Hclk,
  input logic Hresetn,
  ahb_bridge_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0] state;
  logic last_gnt, win, take;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0] wd_cnt;
  always_comb begin
    win = (bus.req0_valid & bus.req1_valid) ? ~last_gnt : bus.req1_valid;
    take = (state == S_IDLE) & (bus.req0_valid | bus.req1_valid);
  end
  assign bus.req0_ready = take & ~win;
  assign bus.req1_ready = take & win;
  assign bus.Hreadyin = bus.Hreadyout;
  assign bus.busy = state != S_IDLE;
  assign bus.rsp0_valid = (state == S_RESP) & ~bus.gnt_id;
  assign bus.rsp1_valid = (state == S_RESP) & bus.gnt_id;
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      state <= S_IDLE;
      last_gnt <= 1'b1;
      wdata_q <= '0;
      wd_cnt <= '0;
      bus.Haddr <= '0;
      bus.Hwrite <= 1'b0;
      bus.Htrans <= 2'b00;
      bus.Hwdata <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.gnt_id <= 1'b0;
      bus.timeout_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          state <= S_ADDR;
          bus.Haddr <= win ? bus.req1_addr : bus.req0_addr;
          bus.Hwrite <= win ? bus.req1_write : bus.req0_write;
          wdata_q <= win ? bus.req1_wdata : bus.req0_wdata;
          bus.Htrans <= 2'b10;
          bus.gnt_id <= win;
          last_gnt <= win;
        end
        S_ADDR: if (bus.Hreadyout) begin
          state <= S_DATA;
          bus.Htrans <= 2'b00;
          wd_cnt <= '0;
          if (bus.Hwrite) bus.Hwdata <= wdata_q;
        end
        S_DATA: if (bus.Hreadyout) begin
          state <= S_RESP;
          if (!bus.Hwrite) bus.rsp_rdata <= bus.Hrdata;
          bus.rsp_err <= bus.Hresp[0];
        end else if (wd_cnt != CW'(TIMEOUT)) begin
          // saturating wait counter; the flag is sticky and never aborts the transfer
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt == CW'(TIMEOUT - 1)) bus.timeout_flag <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter: table-driven and randomized transfers checked against a transaction-level model
module tb_ahb_bridge_arbiter;
  localparam int TO = 16;
  typedef struct {
    logic v0, v1, wr0, wr1;
    logic [31:0] addr0, addr1, wd0, wd1;
    int wa, wdt;
    logic err;
    logic [31:0] hrdata;
    logic exp_gnt, exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic model_last = 1'b1;
  logic exp_tflag = 1'b0;
  logic [31:0] model_rdata = '0;
  logic [31:0] model_hwdata = '0;
  vec_t tbl [10];
  always #5 Hclk = ~Hclk;
  ahb_bridge_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ahb_bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, v1, wr0, wr1, input logic [31:0] a0, a1, d0, d1,
                              input int wa, wdt, input logic err, input logic [31:0] hr,
                              input logic eg, ee, input logic [31:0] er);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.wr0 = wr0; v.wr1 = wr1;
    v.addr0 = a0; v.addr1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.wa = wa; v.wdt = wdt; v.err = err; v.hrdata = hr;
    v.exp_gnt = eg; v.exp_err = ee; v.exp_rdata = er;
    return v;
  endfunction

  task automatic garbage_inputs();
    bus.req0_valid = 1'($urandom_range(1));
    bus.req1_valid = 1'($urandom_range(1));
    bus.req0_write = 1'($urandom_range(1));
    bus.req1_write = 1'($urandom_range(1));
    bus.req0_addr = $urandom;
    bus.req1_addr = $urandom;
    bus.req0_wdata = $urandom;
    bus.req1_wdata = $urandom;
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "_htrans"}, 32'(bus.Htrans), 0);
    check({tag, "_haddr"}, bus.Haddr, 0);
    check({tag, "_hwdata"}, bus.Hwdata, 0);
    check({tag, "_hwrite"}, 32'(bus.Hwrite), 0);
    check({tag, "_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_err"}, 32'(bus.rsp_err), 0);
    check({tag, "_gnt"}, 32'(bus.gnt_id), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_tflag"}, 32'(bus.timeout_flag), 0);
    check({tag, "_rsp"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
  endtask

  task automatic run_xfer(input vec_t v);
    logic [31:0] a, d;
    logic w;
    a = v.exp_gnt ? v.addr1 : v.addr0;
    d = v.exp_gnt ? v.wd1 : v.wd0;
    w = v.exp_gnt ? v.wr1 : v.wr0;
    @(negedge Hclk);
    bus.req0_valid = v.v0; bus.req1_valid = v.v1;
    bus.req0_write = v.wr0; bus.req1_write = v.wr1;
    bus.req0_addr = v.addr0; bus.req1_addr = v.addr1;
    bus.req0_wdata = v.wd0; bus.req1_wdata = v.wd1;
    bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
    #1;
    check("ready0", 32'(bus.req0_ready), 32'(v.exp_gnt == 1'b0));
    check("ready1", 32'(bus.req1_ready), 32'(v.exp_gnt == 1'b1));
    check("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_htrans", 32'(bus.Htrans), 0);
    for (int i = 0; i <= v.wa; i++) begin
      @(negedge Hclk);
      garbage_inputs();
      bus.Hreadyout = (i == v.wa);
      #1;
      check("addr_htrans", 32'(bus.Htrans), 32'h2);
      check("addr_haddr", bus.Haddr, a);
      check("addr_hwrite", 32'(bus.Hwrite), 32'(w));
      check("addr_gnt", 32'(bus.gnt_id), 32'(v.exp_gnt));
      check("addr_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
      check("hreadyin", 32'(bus.Hreadyin), 32'(bus.Hreadyout));
    end
    if (w) model_hwdata = d;
    for (int i = 0; i <= v.wdt; i++) begin
      @(negedge Hclk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.Hreadyout = (i == v.wdt);
      bus.Hresp = (v.err && i >= v.wdt - 1) ? 2'b01 : 2'b00;
      bus.Hrdata = (i == v.wdt) ? v.hrdata : $urandom;
      #1;
      check("data_htrans", 32'(bus.Htrans), 0);
      check("data_hwdata", bus.Hwdata, model_hwdata);
      check("data_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      check("data_tflag", 32'(bus.timeout_flag), 32'(exp_tflag | (i >= TO)));
    end
    if (v.wdt >= TO) exp_tflag = 1'b1;
    @(negedge Hclk);
    garbage_inputs();
    bus.Hresp = 2'b00;
    #1;
    check("rsp0_valid", 32'(bus.rsp0_valid), 32'(v.exp_gnt == 1'b0));
    check("rsp1_valid", 32'(bus.rsp1_valid), 32'(v.exp_gnt == 1'b1));
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("resp_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
    check("resp_tflag", 32'(bus.timeout_flag), 32'(exp_tflag));
    model_last = v.exp_gnt;
    model_rdata = v.exp_rdata;
  endtask

  initial begin
    vec_t v;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_write = 0; bus.req1_write = 0;
    bus.req0_addr = 0; bus.req1_addr = 0; bus.req0_wdata = 0; bus.req1_wdata = 0;
    bus.Hreadyout = 1; bus.Hresp = 0; bus.Hrdata = 0;
    tbl[0] = mk(1, 0, 1, 0, 32'h8000_0010, 0, 32'hA5A5_0001, 0, 0, 0, 0, 32'hFFFF_0000, 0, 0, 32'h0);
    tbl[1] = mk(0, 1, 0, 0, 0, 32'h8000_0020, 0, 0, 0, 2, 0, 32'h1234_5678, 1, 0, 32'h1234_5678);
    tbl[2] = mk(1, 1, 1, 0, 32'h8000_0100, 32'h8000_0104, 32'h1111_0002, 32'h2222_0002, 1, 0, 0, 32'h9999_0002, 0, 0, 32'h1234_5678);
    tbl[3] = mk(1, 1, 1, 0, 32'h8000_0110, 32'h8000_0114, 32'h1111_0003, 32'h2222_0003, 0, 1, 0, 32'hCAFE_0004, 1, 0, 32'hCAFE_0004);
    tbl[4] = mk(1, 1, 0, 1, 32'h8000_0120, 32'h8000_0124, 32'h1111_0005, 32'h2222_0005, 0, 0, 0, 32'h0BAD_0005, 0, 0, 32'h0BAD_0005);
    tbl[5] = mk(1, 1, 0, 1, 32'h8000_0130, 32'h8000_0134, 32'h1111_0006, 32'h2222_0006, 0, 0, 0, 32'h7777_0006, 1, 0, 32'h0BAD_0005);
    tbl[6] = mk(1, 0, 1, 0, 32'h8000_0200, 0, 32'h3333_0007, 0, 0, 1, 1, 32'h4444_0007, 0, 1, 32'h0BAD_0005);
    tbl[7] = mk(0, 1, 0, 0, 0, 32'h8000_0204, 0, 0, 0, 0, 0, 32'h600D_0008, 1, 0, 32'h600D_0008);
    tbl[8] = mk(1, 0, 0, 0, 32'h8000_0300, 0, 0, 0, 0, 20, 0, 32'h0000_DEAD, 0, 0, 32'h0000_DEAD);
    tbl[9] = mk(0, 1, 0, 1, 0, 32'h8000_0304, 0, 32'h5555_0010, 0, 0, 0, 32'h0000_0001, 1, 0, 32'h0000_DEAD);
    #1;
    zero_outputs("reset");
    check("reset_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    for (int k = 0; k < 10; k++) run_xfer(tbl[k]);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge Hclk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        check("gap_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
        check("gap_busy", 32'(bus.busy), 0);
      end
      v.v0 = 1'($urandom_range(1));
      v.v1 = 1'($urandom_range(1));
      if (!v.v0 && !v.v1) v.v1 = 1'b1;
      v.wr0 = 1'($urandom_range(1)); v.wr1 = 1'($urandom_range(1));
      v.addr0 = $urandom; v.addr1 = $urandom; v.wd0 = $urandom; v.wd1 = $urandom;
      v.wa = $urandom_range(2); v.wdt = $urandom_range(3);
      v.err = (v.wdt > 0) && ($urandom_range(3) == 0);
      v.hrdata = $urandom;
      v.exp_gnt = (v.v0 && v.v1) ? ~model_last : v.v1;
      v.exp_err = v.err;
      v.exp_rdata = (v.exp_gnt ? v.wr1 : v.wr0) ? model_rdata : v.hrdata;
      run_xfer(v);
    end
    @(negedge Hclk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0; bus.req0_write = 1'b1;
    bus.req0_addr = 32'h8000_0400; bus.req0_wdata = 32'h0000_BEEF; bus.Hreadyout = 1'b1;
    @(negedge Hclk);
    bus.req0_valid = 1'b0;
    @(negedge Hclk);
    bus.Hreadyout = 1'b0;
    #1;
    check("pre_reset_busy", 32'(bus.busy), 1);
    check("pre_reset_hwdata", bus.Hwdata, 32'h0000_BEEF);
    #1 Hresetn = 1'b0;
    #1;
    zero_outputs("midrst");
    @(negedge Hclk);
    Hresetn = 1'b1;
    bus.Hreadyout = 1'b1;
    repeat (2) begin
      @(negedge Hclk);
      #1;
      check("post_rst_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      check("post_rst_busy", 32'(bus.busy), 0);
    end
    model_last = 1'b1; model_rdata = '0; model_hwdata = '0; exp_tflag = 1'b0;
    run_xfer(mk(1, 1, 0, 0, 32'h8000_0500, 32'h8000_0504, 0, 0, 0, 0, 0, 32'h0F0F_0F0F, 0, 0, 32'h0F0F_0F0F));
    run_xfer(mk(1, 1, 1, 1, 32'h8000_0510, 32'h8000_0514, 32'h1, 32'h2, 0, 0, 0, 32'h0, 1, 0, 32'h0F0F_0F0F));
    @(negedge Hclk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
